// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for io_bus_arbiter: FSM state encodings, master ids and init constant.
package io_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IO_ARB_IDLE  = 2'd0,
    IO_ARB_ISSUE = 2'd1,
    IO_ARB_ACK   = 2'd2
  } io_arb_state_t;

  localparam logic IO_ARB_M0 = 1'b0;
  localparam logic IO_ARB_M1 = 1'b1;

  localparam logic [31:0] IO_INIT_32 = 32'h0000_0000;

endpackage

// File: rtl/io_bus_arbiter_pick.sv
// Combinational winner selection for io_bus_arbiter: fixed priority or round-robin by pointer.
module io_arb_pick
  import io_bus_arbiter_pkg::*;
#(
  parameter bit FAIR = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = IO_ARB_M0;
    if (req0 && req1) begin
      // ptr names the master that has priority on a tie
      winner = FAIR ? ptr : IO_ARB_M0;
    end else if (req1) begin
      winner = IO_ARB_M1;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter/sequencer for the memory-mapped I/O port (IDLE -> ISSUE -> ACK).
// Define IO_ARB_FAIR_EN for round-robin arbitration; default is fixed priority to master 0.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              io_mem_write,
  output logic [ADDR_W-1:0] io_mem_addr,
  output logic [DATA_W-1:0] io_write_data,
  input  logic [DATA_W-1:0] io_read_data
);

  io_arb_state_t r_state, w_state_nxt;
  logic          r_grant;
  logic          w_valid, w_win, w_ptr;
  logic          w_grant_now;

  assign w_grant_now = (r_state == IO_ARB_IDLE) && w_valid;

`ifdef IO_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
  logic r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= IO_ARB_M0;
    end else if (w_grant_now) begin
      r_ptr <= ~w_win;
    end
  end

  assign w_ptr = r_ptr;
`else
  localparam bit FAIR = 1'b0;
  assign w_ptr = IO_ARB_M0;
`endif

  io_arb_pick #(.FAIR(FAIR)) u_pick (
    .req0  (req0),
    .req1  (req1),
    .ptr   (w_ptr),
    .valid (w_valid),
    .winner(w_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IO_ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IO_ARB_IDLE:  if (w_valid) w_state_nxt = IO_ARB_ISSUE;
      IO_ARB_ISSUE: w_state_nxt = IO_ARB_ACK;
      IO_ARB_ACK:   w_state_nxt = IO_ARB_IDLE;
      default:      w_state_nxt = IO_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant       <= IO_ARB_M0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      busy          <= 1'b0;
      io_mem_write  <= 1'b0;
      io_mem_addr   <= '0;
      io_write_data <= '0;
      rdata0        <= '0;
      rdata1        <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      busy <= (w_state_nxt != IO_ARB_IDLE);
      unique case (r_state)
        IO_ARB_IDLE: begin
          if (w_valid) begin
            r_grant       <= w_win;
            io_mem_write  <= w_win ? we1    : we0;
            io_mem_addr   <= w_win ? addr1  : addr0;
            io_write_data <= w_win ? wdata1 : wdata0;
          end
        end
        IO_ARB_ISSUE: begin
          // read data is captured on the same edge that commits a write
          if (!io_mem_write) begin
            if (r_grant == IO_ARB_M0) rdata0 <= io_read_data;
            else                      rdata1 <= io_read_data;
          end
          io_mem_write <= 1'b0;
          ack0         <= (r_grant == IO_ARB_M0);
          ack1         <= (r_grant == IO_ARB_M1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomised self-checking bench for io_bus_arbiter against a transaction-level model.
// Honours IO_ARB_FAIR_EN in the model the same way the design does.
module tb_io_bus_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, io_mem_write;
  logic [DW-1:0] rdata0, rdata1, io_write_data, io_read_data;
  logic [AW-1:0] io_mem_addr;

  always #5 clk = ~clk;

  io_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .io_mem_write(io_mem_write), .io_mem_addr(io_mem_addr),
    .io_write_data(io_write_data), .io_read_data(io_read_data)
  );

  // I/O memory seen by the DUT, and the model's own copy
  logic [DW-1:0] dev_mem [1024];
  logic [DW-1:0] ref_mem [1024];
  assign io_read_data = dev_mem[io_mem_addr];
  always @(posedge clk) if (io_mem_write) dev_mem[io_mem_addr] = io_write_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // master agents
  txn_t q0[$], q1[$];
  txn_t cur[2];
  bit   act[2];
  bit   saw_ack[2];
  int   cyc = 0;
  bit   rel_rst = 1'b0;

  // transaction-level model: one access in flight, issued the cycle after grant
  int            m_issue = -10;
  int            m_win;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rval;
  int            m_ptr = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rd0 = '0, e_rd1 = '0;
  int            ack_cnt[2];
  int            last_ack[2];

  task automatic model_reset();
    m_issue = -10; m_ptr = 0;
    e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
  endtask

  task automatic model_step();
    int w;
    if (rst) return;
    if (cyc >= m_issue + 2 && (act[0] || act[1])) begin
`ifdef IO_ARB_FAIR_EN
      if (act[0] && act[1]) w = m_ptr;
`else
      if (act[0] && act[1]) w = 0;
`endif
      else w = act[0] ? 0 : 1;
      m_win = w; m_we = cur[w].we; m_addr = cur[w].addr; m_wdata = cur[w].wdata;
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      m_rval = ref_mem[m_addr];
      m_ptr   = 1 - w;
      m_issue = cyc + 1;
    end
  endtask

  task automatic drive_masters();
    if (act[0] && saw_ack[0]) act[0] = 1'b0;
    if (act[1] && saw_ack[1]) act[1] = 1'b0;
    if (!act[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); act[0] = 1'b1; end
    if (!act[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); act[1] = 1'b1; end
    req0 = act[0]; we0 = cur[0].we; addr0 = cur[0].addr; wdata0 = cur[0].wdata;
    req1 = act[1]; we1 = cur[1].we; addr1 = cur[1].addr; wdata1 = cur[1].wdata;
  endtask

  task automatic check_outputs();
    if (cyc == m_issue) begin e_addr = m_addr; e_wdata = m_wdata; end
    if (cyc == m_issue + 1 && !m_we) begin
      if (m_win == 0) e_rd0 = m_rval; else e_rd1 = m_rval;
    end
    check_eq("ack0",  ack0,  (cyc == m_issue + 1 && m_win == 0));
    check_eq("ack1",  ack1,  (cyc == m_issue + 1 && m_win == 1));
    check_eq("busy",  busy,  (cyc == m_issue || cyc == m_issue + 1));
    check_eq("wr",    io_mem_write, (cyc == m_issue && m_we));
    check_eq("addr",  32'(io_mem_addr), 32'(e_addr));
    check_eq("wdata", io_write_data, e_wdata);
    check_eq("rdata0", rdata0, e_rd0);
    check_eq("rdata1", rdata1, e_rd1);
    saw_ack[0] = ack0; saw_ack[1] = ack1;
    if (ack0) begin ack_cnt[0]++; last_ack[0] = cyc; end
    if (ack1) begin ack_cnt[1]++; last_ack[1] = cyc; end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    cyc++;
    if (rel_rst) begin rst = 1'b0; rel_rst = 1'b0; end
    drive_masters();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      cycle();
      done = (q0.size() == 0) && (q1.size() == 0) && !act[0] && !act[1] && (cyc >= m_issue + 2);
    end
    check_eq("drain_done", done, 1);
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = AW'($urandom_range(0, 15));
    t.wdata = $urandom;
    return t;
  endfunction

  initial begin
    logic [DW-1:0] old_val;
    int c0, c1;
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[10'h101] = 32'h0000_00A5;
    ref_mem[10'h101] = 32'h0000_00A5;

    // reset state, then idle
    #1 check_outputs();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    // single write from master 0
    q0.push_back('{1'b1, 10'h100, 32'hDEADBEEF});
    drain();
    check_eq("wr_commit", dev_mem[10'h100], 32'hDEADBEEF);

    // single read from master 1
    q1.push_back('{1'b0, 10'h101, 32'h1234_5678});
    drain();
    check_eq("rd1_value", rdata1, 32'h0000_00A5);

    // simultaneous requests held for four transactions
    c0 = ack_cnt[0]; c1 = ack_cnt[1];
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rand_txn());
      q1.push_back(rand_txn());
    end
    for (int i = 0; i < 12; i++) cycle();
`ifdef IO_ARB_FAIR_EN
    check_eq("sim_ack0_cnt", 32'(ack_cnt[0] - c0), 2);
    check_eq("sim_ack1_cnt", 32'(ack_cnt[1] - c1), 2);
`else
    check_eq("sim_ack0_cnt", 32'(ack_cnt[0] - c0), 4);
    check_eq("sim_ack1_cnt", 32'(ack_cnt[1] - c1), 0);
`endif
    drain();

    // reset mid-ISSUE of a write
    old_val = dev_mem[10'h200];
    q0.push_back('{1'b1, 10'h200, 32'hCAFE_F00D});
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_wr_drop", io_mem_write, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ack0", ack0, 0);
    model_reset();
    cycle();
    cycle();
    check_eq("rst_no_commit", dev_mem[10'h200], old_val);
    rel_rst = 1'b1;
    drain();
    check_eq("rst_reserve", dev_mem[10'h200], 32'hCAFE_F00D);

    // master 1 arrives during master 0's ISSUE
    q0.push_back('{1'b1, 10'h005, 32'h0BAD_CAFE});
    cycle();
    q1.push_back('{1'b0, 10'h101, 32'h0});
    drain();
    check_eq("ack_gap", 32'(last_ack[1] - last_ack[0]), 3);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (!act[0] && q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_txn());
      if (!act[1] && q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_txn());
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
